// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between requesters and rr_arbiter4.
// RR_ARB_LOCK_EN adds the lock signal.
interface rr_arbiter4_if;
  logic [3:0] req;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_idx;
`ifdef RR_ARB_LOCK_EN
  logic       lock;

  modport master (
    output req,
    output lock,
    input  grant,
    input  grant_valid,
    input  grant_idx
  );

  modport slave (
    input  req,
    input  lock,
    output grant,
    output grant_valid,
    output grant_idx
  );
`else
  modport master (
    output req,
    input  grant,
    input  grant_valid,
    input  grant_idx
  );

  modport slave (
    input  req,
    output grant,
    output grant_valid,
    output grant_idx
  );
`endif
endinterface

// File: rtl/rr_arbiter4.sv
// 4-way round-robin arbiter with registered one-hot grant and tenure cap.
// Optional RR_ARB_LOCK_EN: lock input extends tenure past MAX_HOLD.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_arbiter4_if.slave bus
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;
  localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD - 1);

  logic [0:0] r_state;
  logic [3:0] r_grant;
  logic [1:0] r_idx;
  logic [1:0] r_ptr;
  logic [3:0] r_hold;

  logic       w_lock;
  logic       w_keep;
  logic [1:0] w_base;
  logic [3:0] w_rot;
  logic [1:0] w_off;
  logic       w_hit;
  logic [1:0] w_k;

`ifdef RR_ARB_LOCK_EN
  assign w_lock = bus.lock;
`else
  assign w_lock = 1'b0;
`endif

  assign w_keep = (r_state == S_GRANT)
               && bus.req[r_idx]
               && (w_lock || (r_hold < HOLD_LIM));

  assign w_base = (r_state == S_GRANT)
               ? r_idx + 2'd1 : r_ptr;

  // Rotate req so the highest-priority index sits at bit 0.
  always_comb begin
    w_rot = '0;
    for (int i = 0; i < 4; i++) begin
      w_rot[i] = bus.req[w_base + 2'(i)];
    end
  end

  // Pick the first set bit of the rotated request vector.
  always_comb begin
    w_hit = 1'b1;
    w_off = 2'd0;
    priority case (1'b1)
      w_rot[0]: w_off = 2'd0;
      w_rot[1]: w_off = 2'd1;
      w_rot[2]: w_off = 2'd2;
      w_rot[3]: w_off = 2'd3;
      default:  w_hit = 1'b0;
    endcase
  end

  assign w_k = w_base + w_off;

  // Keep the owner, hand the grant on, or go idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
    end else if (w_keep) begin
      if (r_hold < HOLD_LIM)
        r_hold <= r_hold + 4'd1;
    end else if (w_hit) begin
      r_state <= S_GRANT;
      r_grant <= 4'b0001 << w_k;
      r_idx   <= w_k;
      r_ptr   <= w_k + 2'd1;
      r_hold  <= '0;
    end else begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_idx   <= '0;
      r_hold  <= '0;
    end
  end

  assign bus.grant       = r_grant;
  assign bus.grant_valid = r_state[0];
  assign bus.grant_idx   = r_idx;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4 (MAX_HOLD=4 and MAX_HOLD=1 instances).
// Build with +define+RR_ARB_LOCK_EN to also exercise lock.
module tb_rr_arbiter4;

  logic clk;
  logic rst_n;
  logic lock_v;
  int   n_cmp;
  int   n_bad;

  typedef struct {
    logic [3:0] req;
    logic       lk;
    logic [3:0] exp;
    string      nm;
  } vec_t;

  vec_t vq[$];

  rr_arbiter4_if bus4 ();
  rr_arbiter4_if bus1 ();

`ifdef RR_ARB_LOCK_EN
  assign bus4.lock = lock_v;
  assign bus1.lock = 1'b0;
`endif

  rr_arbiter4 #(.MAX_HOLD(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  rr_arbiter4 #(.MAX_HOLD(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] enc(input logic [3:0] g);
    case (g)
      4'b0010: enc = 2'd1;
      4'b0100: enc = 2'd2;
      4'b1000: enc = 2'd3;
      default: enc = 2'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [3:0] g,
                     input logic v, input logic [1:0] ix,
                     input logic [3:0] e);
    n_cmp++;
    if (g !== e || v !== (|e) || ix !== enc(e)) begin
      n_bad++;
      $display("FAIL %s: got grant=%b valid=%b idx=%0d, want grant=%b valid=%b idx=%0d",
               nm, g, v, ix, e, |e, enc(e));
    end
  endtask

  task automatic add(input logic [3:0] r, input logic lk,
                     input logic [3:0] e, input string nm);
    vec_t t;
    t.req = r;
    t.lk  = lk;
    t.exp = e;
    t.nm  = nm;
    vq.push_back(t);
  endtask

  task automatic step4(input logic [3:0] r, input logic lk,
                       input logic [3:0] e, input string nm);
    bus4.req = r;
    lock_v   = lk;
    @(posedge clk);
    @(negedge clk);
    chk(nm, bus4.grant, bus4.grant_valid, bus4.grant_idx, e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Structural invariants on both instances every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      if (!$onehot0(bus4.grant)
          || bus4.grant_idx !== enc(bus4.grant)
          || bus4.grant_valid !== (|bus4.grant)) begin
        n_bad++;
        $display("FAIL inv4: grant=%b valid=%b idx=%0d",
                 bus4.grant, bus4.grant_valid, bus4.grant_idx);
      end
      n_cmp++;
      if (!$onehot0(bus1.grant)
          || bus1.grant_idx !== enc(bus1.grant)
          || bus1.grant_valid !== (|bus1.grant)) begin
        n_bad++;
        $display("FAIL inv1: grant=%b valid=%b idx=%0d",
                 bus1.grant, bus1.grant_valid, bus1.grant_idx);
      end
    end
  end

  initial begin
    logic [3:0] rot_exp [5];
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    lock_v    = 1'b0;
    bus4.req  = 4'b0000;
    bus1.req  = 4'b0000;

    @(negedge clk);
    chk("rst_state", bus4.grant, bus4.grant_valid,
        bus4.grant_idx, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    add(4'b0000, 1'b0, 4'b0000, "idle0");
    add(4'b0000, 1'b0, 4'b0000, "idle1");
    for (int i = 0; i < 10; i++)
      add(4'b0100, 1'b0, 4'b0100, "single");
    add(4'b0000, 1'b0, 4'b0000, "single_rel");
    for (int i = 0; i < 4; i++)
      add(4'b0011, 1'b0, 4'b0001, "cap_a");
    for (int i = 0; i < 4; i++)
      add(4'b0011, 1'b0, 4'b0010, "cap_b");
    for (int i = 0; i < 2; i++)
      add(4'b0011, 1'b0, 4'b0001, "cap_c");
    add(4'b0000, 1'b0, 4'b0000, "cap_rel");
    add(4'b0001, 1'b0, 4'b0001, "early_own");
    add(4'b1001, 1'b0, 4'b0001, "early_keep");
    add(4'b1000, 1'b0, 4'b1000, "early_hand");
    add(4'b0000, 1'b0, 4'b0000, "early_idle");
    add(4'b0010, 1'b0, 4'b0010, "pre_rst");

    foreach (vq[i])
      step4(vq[i].req, vq[i].lk, vq[i].exp, vq[i].nm);

    // Asynchronous reset mid-grant, well away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", bus4.grant, bus4.grant_valid,
        bus4.grant_idx, 4'b0000);
    bus4.req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    step4(4'b0000, 1'b0, 4'b0000, "post_rst_idle");
    step4(4'b0000, 1'b0, 4'b0000, "post_rst_idle2");

    // Pointer restarts at 0 after reset.
    rot_exp[0] = 4'b0001;
    rot_exp[1] = 4'b0010;
    rot_exp[2] = 4'b0100;
    rot_exp[3] = 4'b1000;
    rot_exp[4] = 4'b0001;
    bus1.req = 4'b1111;
    step4(4'b1111, 1'b0, 4'b0001, "ptr_rst");
    chk("rot0", bus1.grant, bus1.grant_valid,
        bus1.grant_idx, rot_exp[0]);
    for (int i = 1; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rot", bus1.grant, bus1.grant_valid,
          bus1.grant_idx, rot_exp[i]);
    end
    bus1.req = 4'b0000;
    bus4.req = 4'b0000;

`ifdef RR_ARB_LOCK_EN
    do_reset();
    for (int i = 0; i < 10; i++)
      step4(4'b0011, 1'b1, 4'b0001, "lock_hold");
    step4(4'b0011, 1'b0, 4'b0010, "lock_drop");
    step4(4'b0000, 1'b1, 4'b0000, "lock_idle");
    step4(4'b0000, 1'b1, 4'b0000, "lock_idle2");
`else
    do_reset();
    step4(4'b0000, 1'b0, 4'b0000, "final_idle");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
